// File: rtl/display_scheduler_if.sv
// Bundle between the value sources, the scheduler and the seven-segment number path.
// master: source side (timing strobe, lock, activity requests, source values).
// slave:  scheduler side (selected value, index and hold indication).
interface display_scheduler_if #(
  parameter int N_SRC = 4,
  parameter int W     = 32,
  parameter int IW    = 2
);
  logic               en;
  logic               lock;
  logic [N_SRC-1:0]   req;
  logic [N_SRC*W-1:0] data;
  logic [W-1:0]       num;
  logic [IW-1:0]      src;
  logic               override;

  modport master (
    output en, lock, req, data,
    input  num, src, override
  );

  modport slave (
    input  en, lock, req, data,
    output num, src, override
  );
endinterface

// File: rtl/display_scheduler.sv
// Display scheduler: time-shares the seven-segment number path between N_SRC sources.
// Rotates through sources every DWELL strobes; an active source preempts rotation
// and is held on screen for HOLD strobes, with further requests queued round-robin.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_ROTATE | normal rotation, src advances every DWELL en strobes
// ST_HOLD   | a requesting source is pinned on screen for HOLD en strobes
module display_scheduler #(
  parameter int N_SRC = 4,
  parameter int W     = 32,
  parameter int IW    = 2,
  parameter int DWELL = 8,
  parameter int HOLD  = 16
) (
  input  logic                clk,
  input  logic                reset,
  display_scheduler_if.slave  bus
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int HW_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [HW_W-1:0] HOLD_LOAD  = HW_W'(HOLD - 1);
  localparam logic [IW-1:0]   SRC_LAST   = IW'(N_SRC - 1);

  typedef enum logic {
    ST_ROTATE = 1'b0,
    ST_HOLD   = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     src_q, src_d;
  logic [DW_W-1:0]   dwell_q, dwell_d;
  logic [HW_W-1:0]   hold_q, hold_d;
  logic [N_SRC-1:0]  pending_q, pending_d;
  logic [W-1:0]      num_q, num_d;

  logic [N_SRC-1:0]  cand;
  logic [N_SRC-1:0]  req_eff;
  logic [N_SRC-1:0]  grant_oh;
  logic              grant_valid;
  logic [IW-1:0]     grant_idx;
  logic [IW-1:0]     src_inc;

  // Round-robin pick: search starts just after cur and wraps, so cur itself is checked last.
  // The wrap is a compare against N_SRC-1 so non-power-of-two source counts work.
  function automatic logic [IW-1:0] rr_pick(input logic [N_SRC-1:0] vec,
                                            input logic [IW-1:0]    cur);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = cur;
    found = 1'b0;
    idx   = (cur == SRC_LAST) ? 0 : int'(cur) + 1;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && vec[idx[IW-1:0]]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
      idx = (idx == N_SRC - 1) ? 0 : idx + 1;
    end
    return pick;
  endfunction

  assign src_inc = (src_q == SRC_LAST) ? '0 : src_q + IW'(1);
  assign cand    = pending_q | bus.req;

  // Next-state logic: preemption, dwell rotation, hold countdown and queued grants.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dwell_d     = dwell_q;
    hold_d      = hold_q;
    grant_valid = 1'b0;
    grant_idx   = src_q;
    if (!bus.lock) begin
      case (state_q)
        ST_ROTATE: begin
          if (|cand) begin
            grant_valid = 1'b1;
            grant_idx   = rr_pick(cand, src_q);
            src_d       = grant_idx;
            hold_d      = HOLD_LOAD;
            dwell_d     = '0;
            state_d     = ST_HOLD;
          end else if (bus.en) begin
            if (dwell_q == DWELL_LAST) begin
              src_d   = src_inc;
              dwell_d = '0;
            end else begin
              dwell_d = dwell_q + DW_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (bus.req[src_q]) begin
            hold_d = HOLD_LOAD;
          end else if (bus.en) begin
            if (hold_q != '0) begin
              hold_d = hold_q - HW_W'(1);
            end else if (|pending_q) begin
              grant_valid = 1'b1;
              grant_idx   = rr_pick(pending_q, src_q);
              src_d       = grant_idx;
              hold_d      = HOLD_LOAD;
            end else begin
              state_d = ST_ROTATE;
              dwell_d = '0;
            end
          end
        end
        default: state_d = ST_ROTATE;
      endcase
    end
  end

  // Request queue: the held source's own request only refreshes its hold, it never queues.
  always_comb begin
    req_eff  = bus.req;
    grant_oh = '0;
    if (state_q == ST_HOLD) req_eff[src_q] = 1'b0;
    if (grant_valid) grant_oh[grant_idx] = 1'b1;
    pending_d = (pending_q | req_eff) & ~grant_oh;
  end

  // Value mux on the index chosen this cycle, so num follows a select change by one clk.
  always_comb begin
    num_d = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_d == IW'(i)) num_d = bus.data[i*W +: W];
    end
  end

  // State, counters, request queue and output value registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_ROTATE;
      src_q     <= '0;
      dwell_q   <= '0;
      hold_q    <= '0;
      pending_q <= '0;
      num_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dwell_q   <= dwell_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      num_q     <= num_d;
    end
  end

  assign bus.num      = num_q;
  assign bus.src      = src_q;
  assign bus.override = (state_q == ST_HOLD);

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: directed scenarios, a behavioural model checked every
// cycle, and literal expectations at key points of each scenario.
module tb_display_scheduler;
  localparam int NS    = 4;
  localparam int W     = 32;
  localparam int IW    = 2;
  localparam int DWELL = 4;
  localparam int HOLD  = 3;

  localparam logic [31:0] D0 = 32'h0000_00A0;
  localparam logic [31:0] D1 = 32'h0000_B1B1;
  localparam logic [31:0] D2 = 32'h00C2_C2C2;
  localparam logic [31:0] D3 = 32'hD3D3_D3D3;
  localparam logic [31:0] D1B = 32'h5555_AAAA;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic cmp_on   = 1'b0;

  display_scheduler_if #(.N_SRC(NS), .W(W), .IW(IW)) bus ();

  display_scheduler #(.N_SRC(NS), .W(W), .IW(IW), .DWELL(DWELL), .HOLD(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model view: in_hold, shown = en strobes seen on the current source during rotation,
  // left = en strobes remaining before the held source is released.
  typedef struct packed {
    logic        in_hold;
    int          src;
    int          shown;
    int          left;
    logic [3:0]  pend;
    logic [31:0] num;
  } model_t;

  model_t m;

  function automatic int rr(input logic [3:0] vec, input int cur);
    for (int k = 1; k <= NS; k++) begin
      if (vec[(cur + k) % NS]) return (cur + k) % NS;
    end
    return cur;
  endfunction

  function automatic model_t model_step(input model_t c, input logic e, input logic lk,
                                        input logic [3:0] rq, input logic [127:0] dat);
    model_t n;
    int     pick;
    n = c;
    if (c.in_hold) n.pend = c.pend | (rq & ~(4'b0001 << c.src));
    else           n.pend = c.pend | rq;
    if (!lk) begin
      if (!c.in_hold) begin
        if ((c.pend | rq) != 4'b0) begin
          pick         = rr(c.pend | rq, c.src);
          n.in_hold    = 1'b1;
          n.src        = pick;
          n.left       = HOLD;
          n.shown      = 0;
          n.pend[pick] = 1'b0;
        end else if (e) begin
          n.shown = c.shown + 1;
          if (n.shown == DWELL) begin
            n.src   = (c.src + 1) % NS;
            n.shown = 0;
          end
        end
      end else begin
        if (rq[c.src]) begin
          n.left = HOLD;
        end else if (e) begin
          n.left = c.left - 1;
          if (n.left == 0) begin
            if (c.pend != 4'b0) begin
              pick         = rr(c.pend, c.src);
              n.src        = pick;
              n.left       = HOLD;
              n.pend[pick] = 1'b0;
            end else begin
              n.in_hold = 1'b0;
              n.shown   = 0;
            end
          end
        end
      end
    end
    n.num = dat[n.src*32 +: 32];
    return n;
  endfunction

  // Model advances on the same edges as the design, from the inputs it sees there.
  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '0;
    else        m <= model_step(m, bus.en, bus.lock, bus.req, bus.data);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_num", bus.num, m.num);
      check("model_src", {30'b0, bus.src}, m.src);
      check("model_override", {31'b0, bus.override}, {31'b0, m.in_hold});
    end
  end

  task automatic strobe(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (9) @(negedge clk);
      bus.en = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
    end
  endtask

  task automatic pulse_req(input logic [3:0] r);
    bus.req = r;
    @(negedge clk);
    bus.req = 4'b0;
  endtask

  task automatic lit(input string name, input logic [1:0] s, input logic ov,
                     input logic [31:0] n);
    check({name, "_src"}, {30'b0, bus.src}, {30'b0, s});
    check({name, "_override"}, {31'b0, bus.override}, {31'b0, ov});
    check({name, "_num"}, bus.num, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    bus.en   = 1'b0;
    bus.lock = 1'b0;
    bus.req  = 4'b0;
    bus.data = {D3, D2, D1, D0};
    repeat (3) @(negedge clk);
    lit("reset", 2'd0, 1'b0, 32'h0);
    cmp_on = 1'b1;
    reset  = 1'b1;
    @(negedge clk);
    lit("post_reset", 2'd0, 1'b0, D0);

    // Plain rotation, one step per DWELL strobes.
    strobe(3);
    lit("rot_dwell3", 2'd0, 1'b0, D0);
    strobe(1);
    lit("rot_1", 2'd1, 1'b0, D1);
    strobe(4);
    lit("rot_2", 2'd2, 1'b0, D2);
    strobe(4);
    lit("rot_3", 2'd3, 1'b0, D3);
    strobe(4);
    lit("rot_wrap", 2'd0, 1'b0, D0);

    // Preemption by source 2, held for HOLD strobes, rotation resumes from it.
    pulse_req(4'b0100);
    lit("pre_grant", 2'd2, 1'b1, D2);
    strobe(2);
    lit("pre_hold2", 2'd2, 1'b1, D2);
    strobe(1);
    lit("pre_exit", 2'd2, 1'b0, D2);
    strobe(4);
    lit("pre_resume", 2'd3, 1'b0, D3);

    // Two queued requests while holding 2: served 3 then 1, then back to rotation.
    pulse_req(4'b0100);
    lit("q_grant2", 2'd2, 1'b1, D2);
    pulse_req(4'b1010);
    strobe(3);
    lit("q_first", 2'd3, 1'b1, D3);
    strobe(3);
    lit("q_second", 2'd1, 1'b1, D1);
    strobe(3);
    lit("q_done", 2'd1, 1'b0, D1);

    // Held source keeps refreshing its own hold.
    pulse_req(4'b0100);
    for (int i = 0; i < 5; i++) begin
      strobe(2);
      pulse_req(4'b0100);
    end
    lit("refresh_held", 2'd2, 1'b1, D2);
    strobe(2);
    lit("refresh_tail", 2'd2, 1'b1, D2);
    strobe(1);
    lit("refresh_exit", 2'd2, 1'b0, D2);

    // Lock freezes selection; a request latched under lock is served on release.
    strobe(12);
    lit("lock_pre", 2'd1, 1'b0, D1);
    bus.lock = 1'b1;
    pulse_req(4'b0001);
    strobe(10);
    bus.data[63:32] = D1B;
    @(negedge clk);
    lit("lock_data", 2'd1, 1'b0, D1B);
    strobe(10);
    lit("lock_frozen", 2'd1, 1'b0, D1B);
    bus.lock = 1'b0;
    @(negedge clk);
    lit("lock_release", 2'd0, 1'b1, D0);

    // Reset in the middle of a hold with two requests queued.
    pulse_req(4'b1010);
    strobe(1);
    lit("rst_pre", 2'd0, 1'b1, D0);
    #2 reset = 1'b0;
    #1 lit("rst_now", 2'd0, 1'b0, 32'h0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    lit("rst_after", 2'd0, 1'b0, D0);
    strobe(3);
    lit("rst_nopend", 2'd0, 1'b0, D0);
    strobe(1);
    lit("rst_rot", 2'd1, 1'b0, D1B);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Time-shares the 32-bit seven-segment number path between N_SRC value sources (strobe counter, FSM counters, encoder value, ...).
- In normal operation it rotates through the sources, showing each for a fixed number of display strobes.
- When a source signals activity, it preempts the rotation and holds that source on screen for a while.
- It sits between the source counters and the seven_segment instance in top. It replaces the static switch mux feeding the num input.

Parameters:
N_SRC, 4, number of sources (>= 2; need not be a power of two)
W, 32, width of each source value and of num
IW, 2, index width; must satisfy 2**IW >= N_SRC
DWELL, 8, en strobes each source is shown during rotation (>= 1)
HOLD, 16, en strobes a preempting source is held (>= 1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-low (0 = reset)
en  input  1  one-clk-wide slow timing strobe; dwell and hold counters advance only on en
lock  input  1  level; 1 freezes index, state and both counters
req  input  N_SRC  per-source activity pulse or level, sampled every clk
data  input  N_SRC*W  flattened source values; source i at bits [i*W +: W]
num  output  W  registered value of the selected source
src  output  IW  index of the selected source
override  output  1  1 while in HOLD state

Behaviour:
- Reset (reset == 0, async) clears everything to zero:
  - state = ROTATE, src = 0
  - dwell_cnt = 0, hold_cnt = 0, pending = 0
  - num = 0, override = 0
- num register:
  - Every clk, num <= data[src_next*W +: W], where src_next is the index chosen in the same cycle.
  - Result: one-clk latency from a select change to num. A data change with src stable appears on num the next clk.
- pending register (N_SRC bits):
  - pending_next = (pending | req) & ~grant_onehot.
  - A req from the source currently held in HOLD is absorbed: it reloads the hold count and does not set pending.
  - pending keeps latching while lock = 1.
- Grant selection:
  - Round-robin over (pending | req).
  - Search starts at (src+1) mod N_SRC, then ascends with wrap. src itself is checked last.
  - Modulo uses a compare, not bit truncation.
- State ROTATE:
  - If any (pending | req) bit is set and lock = 0: grant it, src <= granted index, hold_cnt <= HOLD-1, dwell_cnt <= 0, go to HOLD.
  - Else on en: if dwell_cnt == DWELL-1, then src <= (src+1) mod N_SRC and dwell_cnt <= 0; otherwise dwell_cnt++.
  - Preemption beats dwell expiry in the same cycle.
- State HOLD (override = 1):
  - req[src] set: hold_cnt <= HOLD-1. Reload wins over en in that cycle.
  - Else on en with hold_cnt != 0: hold_cnt--.
  - On en with hold_cnt == 0:
    - If pending is nonzero: grant the next pending source round-robin from src+1, reload hold_cnt, stay in HOLD.
    - Else: go to ROTATE with dwell_cnt = 0 and src unchanged, so rotation resumes from the held source.
- lock = 1:
  - No state, src, dwell_cnt or hold_cnt change, and no grants.
  - num still tracks data[src].
  - On release, pending requests are served first.
- Counter widths: dwell_cnt is clog2(DWELL) bits and hold_cnt is clog2(HOLD) bits (1 bit minimum). There is no wrap past the terminal value.
- DWELL = 1: src advances on every en strobe.
- Reset asserted mid-hold: all state is dropped immediately and pending is lost.

Test Plan:
- N_SRC=4, DWELL=4, HOLD=3, no req, en every 10 clk -> src steps 0,1,2,3,0, one step per 4 en pulses; num = data[src] one clk after each step; override = 0 throughout.
- During rotation at src=0, pulse req[2] for one clk -> next clk src=2 and override=1; it stays 3 en pulses, then override=0; src=3 after 4 more en.
- In HOLD on src=2, pulse req[1] and req[3] in the same clk -> after hold expires src=3, then after the next hold expires src=1, then return to ROTATE.
- In HOLD on src=2, pulse req[2] every 2 en -> hold never expires and src stays 2; stop the pulses -> exit 3 en later.
- lock=1 while src=1, pulse req[0], run 20 en -> src, state and counters unchanged; drop lock -> next clk src=0, override=1.
- Assert reset (0) for one clk in the middle of HOLD with pending=4'b1010 -> src=0, num=0, override=0, pending=0 immediately; rotation restarts from 0.
